// File: rtl/level_sensor_conditioner.sv
// Level-probe and mode-switch conditioner: 2-flop sync, tick-based debounce, mode masking, fault flag.
// Optional SENSOR_ERR_LATCH_EN makes E sticky until err_clr while levels are valid.
module level_sensor_conditioner #(
   parameter int unsigned DIV       = 50000,
   parameter int unsigned DEB_TICKS = 10,
   parameter int unsigned ERR_TICKS = 5
) (
   input  logic clock,
   input  logic reset_n,
   input  logic s_high,
   input  logic s_mid,
   input  logic s_low,
   input  logic sw_bs,
   input  logic sw_vs,
   input  logic err_clr,
   output logic H,
   output logic M,
   output logic L,
   output logic Bs,
   output logic Vs,
   output logic E,
   output logic mode_conflict,
   output logic tick
);

   localparam int unsigned NumIn = 5;
   localparam int unsigned PW    = $clog2(DIV) + 1;
   localparam int unsigned DW    = $clog2(DEB_TICKS) + 1;
   localparam int unsigned EW    = $clog2(ERR_TICKS) + 1;

   localparam logic [PW-1:0] PreLast = PW'(DIV - 1);
   localparam logic [DW-1:0] DebLast = DW'(DEB_TICKS - 1);
   localparam logic [EW-1:0] ErrLast = EW'(ERR_TICKS - 1);

   // Bit order: 0 high, 1 mid, 2 low, 3 sprinkler, 4 drip.
   logic [NumIn-1:0] raw;
   logic [NumIn-1:0] sync1_q, sync2_q;
   logic [NumIn-1:0] deb_q, deb_d;
   logic [DW-1:0]    dcnt_q [NumIn];
   logic [DW-1:0]    dcnt_d [NumIn];
   logic [PW-1:0]    pre_q, pre_d;
   logic             e_q, e_d;
   logic [EW-1:0]    ecnt_q, ecnt_d;
   logic             invalid;

   assign raw = {sw_vs, sw_bs, s_low, s_mid, s_high};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   assign tick  = (pre_q == PreLast);
   assign pre_d = tick ? '0 : pre_q + 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NumIn; i++) begin
         dcnt_d[i] = dcnt_q[i];
         if (tick) begin
            if (sync2_q[i] == deb_q[i]) begin
               dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DebLast) begin
               deb_d[i]  = ~deb_q[i];
               dcnt_d[i] = '0;
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         deb_q <= '0;
         for (int i = 0; i < NumIn; i++) begin
            dcnt_q[i] <= '0;
         end
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < NumIn; i++) begin
            dcnt_q[i] <= dcnt_d[i];
         end
      end
   end

   // A wetter probe above a dry one cannot happen physically.
   assign invalid = (deb_q[0] & ~deb_q[1]) | (deb_q[1] & ~deb_q[2]) | (deb_q[0] & ~deb_q[2]);

`ifdef SENSOR_ERR_LATCH_EN
   always_comb begin
      e_d    = e_q;
      ecnt_d = ecnt_q;
      if (!e_q) begin
         if (tick) begin
            if (!invalid) begin
               ecnt_d = '0;
            end else if (ecnt_q == ErrLast) begin
               e_d    = 1'b1;
               ecnt_d = '0;
            end else begin
               ecnt_d = ecnt_q + 1'b1;
            end
         end
      end else if (err_clr && !invalid) begin
         e_d    = 1'b0;
         ecnt_d = '0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;

   // Counts ticks that disagree with the current flag; symmetric hysteresis.
   always_comb begin
      e_d    = e_q;
      ecnt_d = ecnt_q;
      if (tick) begin
         if (invalid == e_q) begin
            ecnt_d = '0;
         end else if (ecnt_q == ErrLast) begin
            e_d    = ~e_q;
            ecnt_d = '0;
         end else begin
            ecnt_d = ecnt_q + 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         e_q    <= 1'b0;
         ecnt_q <= '0;
      end else begin
         e_q    <= e_d;
         ecnt_q <= ecnt_d;
      end
   end

   assign H             = deb_q[0];
   assign M             = deb_q[1];
   assign L             = ~deb_q[2];
   assign E             = e_q;
   assign mode_conflict = deb_q[3] & deb_q[4];
   assign Bs            = deb_q[3] & ~deb_q[4];
   assign Vs            = deb_q[4] & ~deb_q[3];

endmodule

// File: doc/level_sensor_conditioner.md
Name: level_sensor_conditioner

Overview:
- Upstream stage of the irrigation control FSM.
- Converts raw, bouncy, asynchronous inputs into the clean level signals the FSM consumes: three water-box level probes and two irrigation-mode switches.
- Outputs H, M, L, Bs, Vs and the fault flag E.
- Synchronises each input, debounces it on a prescaled sample tick, masks conflicting mode selections, and raises E on physically impossible probe combinations.

Parameters:
- DIV, 50000: clock cycles per sample tick (1 ms at 50 MHz); must be ≥2.
- DEB_TICKS, 10: consecutive ticks a sample must differ from the debounced value before the debounced value flips; must be ≥1.
- ERR_TICKS, 5: consecutive ticks of invalid (or valid) debounced levels needed to set (or clear) E; must be ≥1.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_high  in  1  raw high probe, 1 = wet
- s_mid  in  1  raw middle probe, 1 = wet
- s_low  in  1  raw low probe, 1 = wet
- sw_bs  in  1  raw sprinkler-select switch
- sw_vs  in  1  raw drip-select switch
- err_clr  in  1  synchronous fault-clear pulse (used only with the optional feature)
- H  out  1  box full: debounced high probe wet
- M  out  1  debounced middle probe wet
- L  out  1  box low: debounced low probe dry
- Bs  out  1  sprinkler selected (conflict-masked)
- Vs  out  1  drip selected (conflict-masked)
- E  out  1  level-sensor fault
- mode_conflict  out  1  both switches debounced high
- tick  out  1  one-cycle sample strobe (debug/verification)

Behaviour:
- Reset (async assert, release synchronous to clock):
  - Sync flops, debounced regs, prescaler, debounce counters and error counter all go to 0.
  - Outputs: H=0, M=0, L=1, Bs=0, Vs=0, E=0, mode_conflict=0, tick=0.
  - Reset mid-count discards all partial counts.
- Synchroniser: a 2-flop chain per raw input. All later logic sees only synchronised values.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick=1 for the single cycle where the count equals DIV-1.
  - The first tick after reset is at cycle DIV.
- Debounce (per input, independent):
  - On each tick, compare the synchronised sample with the debounced value.
  - If they are equal, the counter clears.
  - If they differ, the counter increments. When it reaches DEB_TICKS, the debounced value toggles (registered, visible the cycle after the tick) and the counter clears.
  - Between ticks, nothing changes.
  - Latency from a clean raw edge: 2 + (1..DIV) + (DEB_TICKS-1)·DIV clocks.
- Level outputs:
  - H = deb_high, M = deb_mid, L = ~deb_low.
  - All are registered; there is no combinational path from inputs to outputs.
- Mode outputs:
  - If deb_bs and deb_vs are both 1: Bs=0, Vs=0, mode_conflict=1.
  - Otherwise Bs=deb_bs, Vs=deb_vs, mode_conflict=0.
- Fault detection:
  - invalid = (deb_high & ~deb_mid) | (deb_mid & ~deb_low) | (deb_high & ~deb_low).
  - Error counter, evaluated on each tick only:
    - When E=0, it counts ticks with invalid=1 and clears on any tick with invalid=0. E sets when the count reaches ERR_TICKS.
    - When E=1, it counts ticks with invalid=0 and clears on any tick with invalid=1. E clears when the count reaches ERR_TICKS.
  - The counter clears on every E transition.
  - H, M and L pass through unchanged while E=1; the FSM decides how to react.
- Counter widths: $clog2 of the respective maximum + 1; no counter ever wraps past its terminal value.
- Simultaneous events:
  - A tick coinciding with a debounced toggle uses the pre-toggle debounced values for fault evaluation (one-tick lag).
  - err_clr arriving in the same cycle as a set condition: the set wins.

Optional Feature:
- Macro: SENSOR_ERR_LATCH_EN.
- Defined:
  - E is sticky once set; automatic clearing is disabled.
  - E clears only on a cycle where err_clr=1 and invalid=0; the error counter clears with it.
  - err_clr while invalid=1 is ignored.
- Undefined:
  - E uses the hysteresis auto-clear described above.
  - err_clr is ignored and has no loads beyond an unused input.

Test Plan:
- Use DIV=4, DEB_TICKS=3, ERR_TICKS=2 for all scenarios.
- Reset: hold reset_n=0 with all raw inputs at 1, then release → H=0, M=0, L=1, E=0 until debounce completes; first tick at cycle 4 after release.
- Clean edge: s_low 0→1 stable, others at 0 → L falls 11–14 clocks after the edge; H and M stay 0; E stays 0.
- Bounce: s_high pulses 1 for 6 clocks (at most 2 ticks), then returns to 0 → H never rises, and the debounce counter is back to 0 after the next tick.
- Fault set and clear: s_low=1, s_mid=0, s_high=1 stable → E rises 2 ticks after H rises. Then s_high=0 → E falls 2 ticks after H falls. Mode outputs are unaffected throughout.
- Mode conflict: sw_bs=1, then sw_vs=1 → Bs=1 after debounce; once deb_vs goes high, Bs=0, Vs=0, mode_conflict=1. Dropping sw_bs → Vs=1, mode_conflict=0.
- Latch (SENSOR_ERR_LATCH_EN defined): produce E=1, then restore valid levels → E stays 1 for ≥10 ticks. err_clr pulse while invalid → no effect. err_clr pulse while valid → E=0 the next cycle.
- Reset mid-operation: assert reset_n=0 midway through a debounce count → outputs return to reset values immediately (async). After release, the full DEB_TICKS count restarts.
